// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field offsets, decoder opcodes,
// the EPC stack entry layout and the interrupt-take state encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int CP0_IE_BIT    = 0;
  localparam int CP0_IM_BASE   = 8;
  localparam int CP0_NEST_BASE = 16;

  // Physical stack storage; NEST_DEPTH never exceeds this.
  localparam int CP0_MAX_DEPTH = 8;

  localparam logic [5:0] OPC_COP0     = 6'b010000;
  localparam logic [4:0] COP0_RS_MFC0 = 5'b00000;
  localparam logic [4:0] COP0_RS_MTC0 = 5'b00100;
  localparam logic [5:0] COP0_FN_ERET = 6'b011000;

  typedef struct packed {
    logic [31:0] epc;
    logic [2:0]  vec;
  } epc_entry_t;

  typedef enum logic {
    TAKE_ARMED = 1'b0,
    TAKE_BLANK = 1'b1
  } take_state_t;

endpackage

// File: rtl/cp0_epc_stack.sv
// Hardware stack of {EPC, vector} entries for nested interrupts.
// Entry 0 keeps its contents when the stack is empty so EPC stays readable.
module cp0_epc_stack
  import cp0_pkg::*;
#(
  parameter int NEST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_top_we,
  input  epc_entry_t  i_push_entry,
  input  logic [31:0] i_top_epc,
  output epc_entry_t  o_top,
  output logic [3:0]  o_depth
);

  epc_entry_t r_entry [CP0_MAX_DEPTH];
  logic [3:0] r_depth;
  logic [2:0] w_top_idx;
  logic [2:0] w_push_idx;
  logic       w_push_ok;
  logic       w_pop_ok;

  assign w_top_idx  = (r_depth == 4'd0) ? 3'd0 : 3'(r_depth - 4'd1);
  assign w_push_idx = r_depth[2:0];
  assign w_push_ok  = i_push && (r_depth < 4'(NEST_DEPTH));
  assign w_pop_ok   = i_pop && (r_depth != 4'd0);

  // Top-EPC overwrite first, then push/pop; a push into an empty stack replaces entry 0 entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
      for (int i = 0; i < CP0_MAX_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      if (i_top_we) begin
        r_entry[w_top_idx].epc <= i_top_epc;
      end
      if (w_push_ok) begin
        r_entry[w_push_idx] <= i_push_entry;
        r_depth             <= r_depth + 4'd1;
      end else if (w_pop_ok) begin
        r_depth <= r_depth - 4'd1;
      end
    end
  end

  assign o_top   = r_entry[w_top_idx];
  assign o_depth = r_depth;

endmodule

// File: rtl/cp0_intc_nested.sv
// Nested-priority CP0 interrupt controller: source sampling, priority encode,
// take sequencing, Status/Cause/EPC register file and the EPC stack.
// Define CP0_INTC_SYNC_EN to add a 2-flop synchroniser on every irq_src bit.
module cp0_intc_nested
  import cp0_pkg::*;
#(
  parameter int                 NUM_IRQ    = 3,
  parameter int                 NEST_DEPTH = 4,
  parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [31:0]        ex_pc,
  input  logic               eret,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_waddr,
  input  logic [31:0]        cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [31:0]        cp0_rdata,
  output logic               int_req,
  output logic [2:0]         int_vector,
  output logic [31:0]        epc_out,
  output logic [3:0]         nest_level
);

  logic [NUM_IRQ-1:0] w_src;
  logic [NUM_IRQ-1:0] r_src_d;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_im;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_clr;
  logic               r_ie;
  logic               r_int_req;
  logic [2:0]         r_int_vec;
  take_state_t        r_state;
  logic               w_any;
  logic [2:0]         w_h;
  logic [3:0]         w_h_plus;
  logic [3:0]         w_level;
  logic [3:0]         w_depth;
  epc_entry_t         w_top;
  epc_entry_t         w_push_entry;
  logic               w_take;
  logic               w_eret_pop;
  logic               w_sw_status;
  logic               w_sw_epc;
  logic [31:0]        w_rdata;

`ifdef CP0_INTC_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  // Two-flop synchroniser for asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_active     = r_pend & r_im;
  assign w_sw_status  = cp0_we && (cp0_waddr == CP0_REG_STATUS);
  assign w_sw_epc     = cp0_we && (cp0_waddr == CP0_REG_EPC);
  assign w_eret_pop   = eret && (w_depth != 4'd0);
  assign w_h_plus     = {1'b0, w_h} + 4'd1;
  assign w_level      = (w_depth == 4'd0) ? 4'd0 : ({1'b0, w_top.vec} + 4'd1);
  assign w_take       = r_ie && (r_state == TAKE_ARMED) && !eret &&
                        (w_depth < 4'(NEST_DEPTH)) && w_any && (w_h_plus > w_level);
  assign w_push_entry = '{epc: ex_pc, vec: w_h};

  // Fixed priority: the highest enabled pending index wins.
  always_comb begin
    w_any = 1'b0;
    w_h   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_active[i]) begin
        w_any = 1'b1;
        w_h   = 3'(i);
      end
    end
  end

  // One-hot clear of the source being taken.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_take && (w_h == 3'(i));
    end
  end

  // Edge sources latch on a rising sample and clear on take (a fresh edge wins); level sources follow the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_d <= '0;
      r_pend  <= '0;
    end else begin
      r_src_d <= w_src;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (LEVEL_MASK[i]) begin
          r_pend[i] <= w_src[i];
        end else begin
          r_pend[i] <= (r_pend[i] & ~w_clr[i]) | (w_src[i] & ~r_src_d[i]);
        end
      end
    end
  end

  // Take sequencer: a one-cycle int_req pulse followed by a blanking cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TAKE_ARMED;
      r_int_req <= 1'b0;
      r_int_vec <= '0;
    end else begin
      r_state   <= w_take ? TAKE_BLANK : TAKE_ARMED;
      r_int_req <= w_take;
      if (w_take) begin
        r_int_vec <= w_h;
      end
    end
  end

  // Status register: a software MTC0 beats the hardware IE clear on take and IE set on ERET.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie <= 1'b0;
      r_im <= '0;
    end else if (w_sw_status) begin
      r_ie <= cp0_wdata[CP0_IE_BIT];
      r_im <= cp0_wdata[CP0_IM_BASE +: NUM_IRQ];
    end else if (w_take) begin
      r_ie <= 1'b0;
    end else if (w_eret_pop) begin
      r_ie <= 1'b1;
    end
  end

  cp0_epc_stack #(
    .NEST_DEPTH (NEST_DEPTH)
  ) u_stack (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_take),
    .i_pop        (w_eret_pop),
    .i_top_we     (w_sw_epc),
    .i_push_entry (w_push_entry),
    .i_top_epc    (cp0_wdata),
    .o_top        (w_top),
    .o_depth      (w_depth)
  );

  // MFC0 read mux; unmapped addresses and unused bits read zero.
  always_comb begin
    w_rdata = '0;
    case (cp0_raddr)
      CP0_REG_STATUS: begin
        w_rdata[CP0_IE_BIT]              = r_ie;
        w_rdata[CP0_IM_BASE +: NUM_IRQ]  = r_im;
      end
      CP0_REG_CAUSE: begin
        w_rdata[CP0_IM_BASE +: NUM_IRQ]  = r_pend;
        w_rdata[CP0_NEST_BASE +: 4]      = w_depth;
      end
      CP0_REG_EPC: begin
        w_rdata = w_top.epc;
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  assign cp0_rdata  = w_rdata;
  assign int_req    = r_int_req;
  assign int_vector = r_int_vec;
  assign epc_out    = w_top.epc;
  assign nest_level = w_depth;

endmodule

// File: tb/tb_cp0_intc_nested.sv
// Scoreboard bench for cp0_intc_nested: directed scenarios then random traffic,
// checked against a queue-based behavioural model of the interrupt rules.
module tb_cp0_intc_nested;

  localparam int            N     = 3;
  localparam int            DEPTH = 2;
  localparam logic [N-1:0]  LVL   = 3'b001;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic [31:0]   ex_pc;
  logic          eret;
  logic          cp0_we;
  logic [4:0]    cp0_waddr;
  logic [31:0]   cp0_wdata;
  logic [4:0]    cp0_raddr;
  logic [31:0]   cp0_rdata;
  logic          int_req;
  logic [2:0]    int_vector;
  logic [31:0]   epc_out;
  logic [3:0]    nest_level;

  cp0_intc_nested #(
    .NUM_IRQ    (N),
    .NEST_DEPTH (DEPTH),
    .LEVEL_MASK (LVL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .ex_pc      (ex_pc),
    .eret       (eret),
    .cp0_we     (cp0_we),
    .cp0_waddr  (cp0_waddr),
    .cp0_wdata  (cp0_wdata),
    .cp0_raddr  (cp0_raddr),
    .cp0_rdata  (cp0_rdata),
    .int_req    (int_req),
    .int_vector (int_vector),
    .epc_out    (epc_out),
    .nest_level (nest_level)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    int          vec;
    logic [31:0] epc;
  } take_t;

  typedef struct {
    logic [31:0] epc;
    int          vec;
  } frame_t;

  take_t        expQ[$];
  frame_t       mStack[$];
  logic [N-1:0] mPend;
  logic [N-1:0] mPrev;
  logic [N-1:0] mIm;
  logic         mIe;
  logic         mReqPrev;
  logic [31:0]  mEpc0;
`ifdef CP0_INTC_SYNC_EN
  logic [N-1:0] mSync1;
  logic [N-1:0] mSync2;
`endif

  int           checks  = 0;
  int           errors  = 0;
  int           edgeNum = 0;
  bit           monOn   = 0;
  logic [N-1:0] curSrc  = '0;

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h, required %h", name, edgeNum, act, exp);
    end
  endtask

  // Reference model: advances one clock using the rules of the interrupt controller.
  task automatic modelStep(input logic rstV, input logic [N-1:0] srcV, input logic [31:0] pcV,
                           input logic eretV, input logic weV, input logic [4:0] waddrV,
                           input logic [31:0] wdataV);
    logic [N-1:0] srcS;
    int           h;
    bit           any;
    int           lvl;
    bit           take;
    bit           popped;
    take_t        t;
    frame_t       f;
`ifdef CP0_INTC_SYNC_EN
    srcS = mSync2;
    if (rstV) begin
      mSync1 = '0;
      mSync2 = '0;
    end else begin
      mSync2 = mSync1;
      mSync1 = srcV;
    end
`else
    srcS = srcV;
`endif
    if (rstV) begin
      mPend    = '0;
      mPrev    = '0;
      mIm      = '0;
      mIe      = 1'b0;
      mReqPrev = 1'b0;
      mEpc0    = '0;
      mStack.delete();
      return;
    end
    any = 0;
    h   = 0;
    for (int i = 0; i < N; i++) begin
      if (mPend[i] && mIm[i]) begin
        any = 1;
        h   = i;
      end
    end
    lvl  = (mStack.size() == 0) ? 0 : mStack[mStack.size()-1].vec + 1;
    take = mIe && !mReqPrev && !eretV && (mStack.size() < DEPTH) && any && (h + 1 > lvl);
    for (int i = 0; i < N; i++) begin
      if (LVL[i]) mPend[i] = srcS[i];
      else        mPend[i] = (mPend[i] && !(take && h == i)) || (srcS[i] && !mPrev[i]);
    end
    mPrev = srcS;
    if (weV && waddrV == 5'd14) begin
      if (mStack.size() == 0) mEpc0 = wdataV;
      else                    mStack[mStack.size()-1].epc = wdataV;
    end
    popped = 0;
    if (take) begin
      t.cyc = edgeNum + 1;
      t.vec = h;
      t.epc = pcV;
      expQ.push_back(t);
      f.epc = pcV;
      f.vec = h;
      mStack.push_back(f);
    end else if (eretV && mStack.size() > 0) begin
      f = mStack.pop_back();
      if (mStack.size() == 0) mEpc0 = f.epc;
      popped = 1;
    end
    if (weV && waddrV == 5'd12) begin
      mIe = wdataV[0];
      mIm = wdataV[8 +: N];
    end else if (take) begin
      mIe = 1'b0;
    end else if (popped) begin
      mIe = 1'b1;
    end
    mReqPrev = take;
  endtask

  // Compares stack depth, EPC and every mapped register read against the model.
  task automatic checkOutput();
    logic [31:0] eStatus;
    logic [31:0] eCause;
    logic [31:0] eEpc;
    int          other;
    eStatus = '0;
    eStatus[0] = mIe;
    eStatus[8 +: N] = mIm;
    eCause = '0;
    eCause[8 +: N] = mPend;
    eCause[16 +: 4] = 4'(mStack.size());
    eEpc = (mStack.size() == 0) ? mEpc0 : mStack[mStack.size()-1].epc;
    compareValue("nest_level", 32'(nest_level), 32'(mStack.size()));
    compareValue("epc_out", epc_out, eEpc);
    cp0_raddr = 5'd12; #1;
    compareValue("status_read", cp0_rdata, eStatus);
    cp0_raddr = 5'd13; #1;
    compareValue("cause_read", cp0_rdata, eCause);
    cp0_raddr = 5'd14; #1;
    compareValue("epc_read", cp0_rdata, eEpc);
    other = $urandom_range(0, 31);
    if (other >= 12 && other <= 14) other = 0;
    cp0_raddr = 5'(other); #1;
    compareValue("unmapped_read", cp0_rdata, 32'h0);
  endtask

  // Drives one cycle of inputs (irq_src from curSrc), steps the model, then checks.
  task automatic applyStimulus(input logic rstV, input logic eretV, input logic weV,
                               input logic [4:0] waddrV, input logic [31:0] wdataV,
                               input logic [31:0] pcV);
    rst       = rstV;
    irq_src   = curSrc;
    ex_pc     = pcV;
    eret      = eretV;
    cp0_we    = weV;
    cp0_waddr = waddrV;
    cp0_wdata = wdataV;
    modelStep(rstV, curSrc, pcV, eretV, weV, waddrV, wdataV);
    @(posedge clk);
    edgeNum++;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [31:0] pc);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, pc);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, 1'b1, a, d, pc);
  endtask

  task automatic doEret(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, pc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises int_req, flags missing or surplus takes.
  always @(negedge clk) begin
    take_t t;
    if (monOn) begin
      if (int_req === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_int at edge %0d: got int_req=1 vector=%0d, required no interrupt",
                   edgeNum, int_vector);
        end else begin
          t = expQ.pop_front();
          compareValue("int_edge", 32'(edgeNum), 32'(t.cyc));
          compareValue("int_vector", 32'(int_vector), 32'(t.vec));
          compareValue("int_epc", epc_out, t.epc);
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= edgeNum) begin
        t = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_int at edge %0d: got int_req=%b, required pulse for vector %0d",
                 edgeNum, int_req, t.vec);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wd;
    int          sel;
    cp0_raddr = 5'd0;
    curSrc    = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    monOn = 1;

    $display("[TB] basic take");
    mtc0(5'd12, 32'h0000_0701, 32'h0);
    curSrc = 3'b010;
    idle(3, 32'h400);
    curSrc = 3'b000;
    idle(2, 32'h404);
    doEret(32'h408);
    idle(2, 32'h40c);

    $display("[TB] nesting over level source 0");
    curSrc = 3'b001;
    idle(3, 32'h100);
    mtc0(5'd12, 32'h0000_0701, 32'h104);
    curSrc = 3'b101;
    idle(3, 32'h800);
    curSrc = 3'b001;
    mtc0(5'd14, 32'h0000_0abc, 32'h804);
    doEret(32'h808);
    idle(2, 32'h80c);
    doEret(32'h810);
    idle(3, 32'h200);
    curSrc = 3'b000;
    doEret(32'h204);
    idle(2, 32'h208);

    $display("[TB] no preemption at equal or lower level");
    curSrc = 3'b100;
    idle(3, 32'h900);
    mtc0(5'd12, 32'h0000_0701, 32'h904);
    curSrc = 3'b110;
    idle(4, 32'h908);
    curSrc = 3'b000;
    doEret(32'h90c);
    idle(3, 32'h910);
    doEret(32'h914);
    idle(2, 32'h918);

    $display("[TB] full stack");
    curSrc = 3'b001;
    idle(3, 32'h300);
    mtc0(5'd12, 32'h0000_0701, 32'h304);
    curSrc = 3'b011;
    idle(3, 32'h308);
    mtc0(5'd12, 32'h0000_0701, 32'h30c);
    curSrc = 3'b111;
    idle(4, 32'h310);
    doEret(32'h314);
    idle(3, 32'h318);
    curSrc = 3'b000;
    repeat (3) doEret(32'h31c);

    $display("[TB] masks, collisions and reset mid-nesting");
    mtc0(5'd12, 32'h0000_0601, 32'h500);
    curSrc = 3'b001;
    idle(3, 32'h504);
    mtc0(5'd12, 32'h0000_0701, 32'h508);
    idle(1, 32'h50c);
    mtc0(5'd12, 32'h0000_0701, 32'h510);
    curSrc = 3'b101;
    idle(1, 32'h514);
    repeat (2) mtc0(5'd12, 32'h0000_0701, 32'h518);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h51c);
    curSrc = 3'b000;
    idle(2, 32'h520);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) curSrc[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        doEret($urandom);
      end else if ($urandom_range(0, 5) == 0) begin
        sel = $urandom_range(0, 5);
        wd  = $urandom;
        if (sel <= 2) begin
          wd[0] = ($urandom_range(0, 3) != 0);
          mtc0(5'd12, wd, $urandom);
        end else if (sel == 3) begin
          mtc0(5'd14, wd, $urandom);
        end else if (sel == 4) begin
          mtc0(5'd13, wd, $urandom);
        end else begin
          mtc0(5'($urandom_range(0, 31)), wd, $urandom);
        end
      end else begin
        idle(1, $urandom);
      end
    end

    curSrc = '0;
    idle(4, 32'h0);
    compareValue("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_intc_nested.md
Name: cp0_intc_nested

Overview:
- Parametrised successor to the single-level CP0 interrupt logic.
- Handles NUM_IRQ edge- or level-sensitive sources with per-source mask bits and fixed priority (higher index wins).
- Supports nested preemption through a hardware stack of EPC/level entries, NEST_DEPTH deep.
- Sits beside the pipeline: reads CP0 registers from ID, takes MTC0 writes from WB, and raises a one-cycle int_req that redirects fetch.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; legal range 1..8.
- NEST_DEPTH, 4, EPC/level stack entries; legal range 1..8.
- LEVEL_MASK, 0, NUM_IRQ-bit vector; bit i=1 makes source i level-sensitive, 0 makes it rising-edge latched.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- irq_src  in  NUM_IRQ  raw interrupt sources
- ex_pc  in  32  PC to save when an interrupt is taken
- eret  in  1  ERET in ID, one-cycle qualified pulse
- cp0_we  in  1  MTC0 write strobe from WB
- cp0_waddr  in  5  CP0 register number
- cp0_wdata  in  32  write data
- cp0_raddr  in  5  MFC0 register number from ID
- cp0_rdata  out  32  combinational read data
- int_req  out  1  registered one-cycle interrupt-taken pulse
- int_vector  out  3  index of the taken source; valid while int_req
- epc_out  out  32  top-of-stack EPC (entry 0 when stack empty)
- nest_level  out  4  current stack depth

Behaviour:
- Reset: clears pending, IE, IM, stack depth, int_req, int_vector, all EPC entries and source history. After reset cp0_rdata=0 for every address and epc_out=0.
- Register map:
  - 12 Status: bit0 IE, bits[8+:NUM_IRQ] IM; other bits read 0.
  - 13 Cause: bits[8+:NUM_IRQ] pending, bits[19:16] nest_level.
  - 14 EPC: top-of-stack entry.
  - Any other address reads 0.
- Pending, edge sources: pending[i] <= 1 at posedge where irq_src[i]=1 and src_d[i]=0 (src_d is the registered previous sample). Cleared when source i is taken. A new edge in the same cycle as the take keeps it set.
- Pending, level sources: pending[i] = registered irq_src[i]; no clear on take.
- Current level L = stored vector+1 of the top entry; L=0 when the stack is empty.
- Take condition, evaluated on pre-edge state:
  - IE=1,
  - int_req=0 (one blanking cycle after each take),
  - eret=0,
  - depth<NEST_DEPTH,
  - h+1 > L, where h is the highest index with pending&IM set.
- On take, at the posedge:
  - int_req<=1 and int_vector<=h,
  - push {ex_pc, h},
  - IE<=0,
  - clear pending[h] (edge sources only).
- Latency: a source rising before edge k sets pending after k; int_req is high after k+1.
- eret with depth>0: pop and set IE<=1. eret with depth=0: ignored, stack and IE unchanged.
- MTC0 12: writes IE and IM. A software write wins over the hardware IE clear (take) and IE set (eret) in the same cycle.
- MTC0 14: overwrites the top entry's EPC field, or entry 0 when empty. The stored vector is unchanged.
- MTC0 13: no effect.
- Full stack (depth=NEST_DEPTH): no take; pending bits are retained.
- Reset mid-nesting: the stack is discarded and a take in that cycle is suppressed.

Optional Feature:
- CP0_INTC_SYNC_EN defined: each irq_src bit passes through a 2-flop synchroniser before edge/level sampling. Latency to int_req grows by 2 cycles.
- Undefined: irq_src is sampled directly; the latency above applies.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers 12/13/14,
  - field offsets (IE bit 0, IM/IP base 8, nest field 16),
  - MTC0/MFC0/ERET opcode constants for the decoder.
- Sub-module cp0_epc_stack (parametrised NEST_DEPTH):
  - push/pop/top-write ports,
  - top entry output,
  - depth output.
- The rest stays flat: sampling, priority encode, take FSM, register file.

Test Plan:
- Basic take: IE=1, IM=3'b111, rise irq_src[1], ex_pc=0x400 -> int_req for one cycle 2 cycles later, int_vector=1, epc_out=0x400, nest_level=1, IE=0.
- Nesting: in handler for source 0, software sets IE=1; rise src[2] with ex_pc=0x800 -> nest_level=2, epc_out=0x800. ERET -> epc_out returns to source 0's EPC, IE=1.
- No preemption at equal or lower level: in handler for source 2 with IE=1, rise src[1] -> no int_req. After ERET -> src[1] taken.
- Full stack: NEST_DEPTH=2, two nested takes, third edge -> no int_req, Cause pending bit set. ERET -> it is taken.
- Collisions: eret together with an eligible pending source -> pop only, take next cycle. MTC0 Status IE=1 in the take cycle -> IE reads 1.
- Masks: src[0] edge with IM[0]=0 -> pending set, no take; set IM[0]=1 -> taken. Level source held high -> re-requests after each ERET.
